// File: rtl/axi_txn_limiter_isolate.sv
// axi_txn_limiter_isolate: AXI4 outstanding-transaction limiter with drain-then-isolate gate
// Ports: clk_i/rst_ni clock and async active-low reset; slv_req_i/slv_resp_o upstream
// master side; mst_req_o/mst_resp_i downstream side; isolate_i drain request;
// isolated_o drained and blocked; rd_cnt_o/wr_cnt_o outstanding read/write counts.
package axi_txn_limiter_isolate_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;
  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    r_t   r;
    logic r_valid;
  } resp_t;
endpackage

module axi_txn_limiter_isolate #(
  parameter int unsigned MaxRdTxn = 2,
  parameter int unsigned MaxWrTxn = 2,
  parameter int unsigned MaxWPend = MaxWrTxn,
  parameter type axi_req_t = axi_txn_limiter_isolate_pkg::req_t,
  parameter type axi_resp_t = axi_txn_limiter_isolate_pkg::resp_t,
  localparam int unsigned RW = $clog2(MaxRdTxn + 1),
  localparam int unsigned WW = $clog2(MaxWrTxn + 1),
  localparam int unsigned PW = $clog2(MaxWPend + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_req_t      slv_req_i,
  output axi_resp_t     slv_resp_o,
  output axi_req_t      mst_req_o,
  input  axi_resp_t     mst_resp_i,
  input  logic          isolate_i,
  output logic          isolated_o,
  output logic [RW-1:0] rd_cnt_o,
  output logic [WW-1:0] wr_cnt_o
);
  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_e;
  state_e state, state_nxt;
  logic [RW-1:0] rd_cnt;
  logic [WW-1:0] wr_cnt;
  logic [PW-1:0] w_pend;
  logic aw_hold, ar_hold, aw_ok, ar_ok, w_ok, aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs, idle;
  // a hold keeps an already-offered address forwarded until it handshakes
  assign aw_ok = (state == RUN && wr_cnt < WW'(MaxWrTxn) && w_pend < PW'(MaxWPend)) || aw_hold;
  assign ar_ok = (state == RUN && rd_cnt < RW'(MaxRdTxn)) || ar_hold;
  assign aw_hs = slv_req_i.aw_valid & aw_ok & mst_resp_i.aw_ready;
  assign ar_hs = slv_req_i.ar_valid & ar_ok & mst_resp_i.ar_ready;
  // W waits for its AW; a same-cycle AW handshake is enough
  assign w_ok = w_pend != '0 || aw_hs;
  assign w_last_hs = slv_req_i.w_valid & w_ok & mst_resp_i.w_ready & slv_req_i.w.last;
  assign b_hs = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign idle = rd_cnt == '0 && wr_cnt == '0 && w_pend == '0 && !aw_hold && !ar_hold;
  assign rd_cnt_o = rd_cnt;
  assign wr_cnt_o = wr_cnt;
  always_comb begin
    mst_req_o = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;
    mst_req_o.w_valid = slv_req_i.w_valid & w_ok;
    slv_resp_o = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
    slv_resp_o.w_ready = mst_resp_i.w_ready & w_ok;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= RUN;
    else state <= state_nxt;
  always_comb
    state_nxt = !isolate_i ? RUN : state == RUN ? DRAIN : (state == DRAIN && !idle) ? DRAIN : ISOLATED;
  always_comb isolated_o = state == ISOLATED;
  // a stray B/R-last at count 0 saturates instead of wrapping
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      w_pend <= '0;
      aw_hold <= 1'b0;
      ar_hold <= 1'b0;
    end else begin
      rd_cnt <= rd_cnt + RW'(ar_hs) - RW'(r_last_hs && (rd_cnt != '0 || ar_hs));
      wr_cnt <= wr_cnt + WW'(aw_hs) - WW'(b_hs && (wr_cnt != '0 || aw_hs));
      w_pend <= w_pend + PW'(aw_hs) - PW'(w_last_hs);
      aw_hold <= mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
      ar_hold <= mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
    end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && wr_cnt == '0 && !aw_hs));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && rd_cnt == '0 && !ar_hs));
endmodule

// File: tb/tb_axi_txn_limiter_isolate.sv
// tb_axi_txn_limiter_isolate: vectors, corner sequences and randomized model check
module tb_axi_txn_limiter_isolate;
  import axi_txn_limiter_isolate_pkg::*;
  logic clk = 0, rst_ni = 0, iso = 0, isolated;
  logic [2:0] rd_cnt;
  logic [1:0] wr_cnt;
  req_t slv_req, mst_req;
  resp_t slv_resp, mst_resp;
  int checks = 0, errors = 0;
  typedef struct { string name; logic [9:0] in; logic [9:0] exp; } vec_t;
  vec_t vt [8];
  int m_mode = 0, wr_out = 0, w_open = 0, b_owed = 0, up_beat = 0;
  int rd_q[$], up_w[$];
  logic m_awh = 0, m_arh = 0, p_aw, p_ar, p_w, aw_hs, ar_hs, w_hs, b_hs, r_hs, idle;
  always #5 clk = ~clk;
  axi_txn_limiter_isolate #(.MaxRdTxn(4), .MaxWrTxn(2), .MaxWPend(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp), .isolate_i(iso), .isolated_o(isolated),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt));
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic restart;
    rst_ni = 0;
    iso = 0;
    slv_req = '0;
    mst_resp = '0;
    tick;
    rst_ni = 1;
  endtask
  function automatic logic [9:0] gates();
    return {mst_req.aw_valid, slv_resp.aw_ready, mst_req.w_valid, slv_resp.w_ready, mst_req.ar_valid,
            slv_resp.ar_ready, slv_resp.b_valid, mst_req.b_ready, slv_resp.r_valid, mst_req.r_ready};
  endfunction
  task automatic drive(input logic [9:0] v);
    {slv_req.aw_valid, mst_resp.aw_ready, slv_req.w_valid, mst_resp.w_ready, slv_req.ar_valid,
     mst_resp.ar_ready, mst_resp.b_valid, slv_req.b_ready, mst_resp.r_valid, slv_req.r_ready} = v;
  endtask
  initial begin
    vt[0] = '{"all_hs",    10'b1111111111, 10'b1111111111};
    vt[1] = '{"w_only",    10'b0011000000, 10'b0000000000};
    vt[2] = '{"aw_wait_w", 10'b1011000000, 10'b1000000000};
    vt[3] = '{"aw_rdy_w",  10'b0111000000, 10'b0100000000};
    vt[4] = '{"ar_hs",     10'b0000110000, 10'b0000110000};
    vt[5] = '{"resp_pass", 10'b0000001111, 10'b0000001111};
    vt[6] = '{"resp_mix",  10'b0000001001, 10'b0000001001};
    vt[7] = '{"aw_w_hs",   10'b1111000000, 10'b1111000000};
    slv_req = '0;
    mst_resp = '0;
    tick;
    chk("reset", {rd_cnt, wr_cnt, isolated}, 0);
    rst_ni = 1;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].in);
      #2;
      chk(vt[i].name, gates(), vt[i].exp);
      restart;
    end
    // write limit with B held back
    slv_req.aw_valid = 1; mst_resp.aw_ready = 1;
    slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.w_ready = 1;
    tick; tick;
    slv_req.w_valid = 0; #1;
    chk("aw_full_rdy", slv_resp.aw_ready, 0);
    chk("aw_full_vld", mst_req.aw_valid, 0);
    chk("aw_full_cnt", wr_cnt, 2);
    mst_resp.b_valid = 1; slv_req.b_ready = 1;
    tick;
    mst_resp.b_valid = 0; #1;
    chk("aw_after_b_cnt", wr_cnt, 1);
    chk("aw_after_b_rdy", slv_resp.aw_ready, 1);
    tick;
    chk("aw_third_cnt", wr_cnt, 2);
    restart;
    // read limit and R-last decrement
    slv_req.ar_valid = 1; slv_req.ar.len = 3; mst_resp.ar_ready = 1;
    repeat (4) tick;
    chk("ar_full_cnt", rd_cnt, 4);
    chk("ar_full_rdy", slv_resp.ar_ready, 0);
    slv_req.ar_valid = 0; mst_resp.r_valid = 1; slv_req.r_ready = 1;
    for (int b = 0; b < 16; b++) begin
      mst_resp.r.last = (b % 4 == 3);
      tick;
      chk("r_beat_cnt", rd_cnt, 4 - (b + 1) / 4);
    end
    restart;
    // isolate with one read and one write outstanding
    slv_req.ar_valid = 1; mst_resp.ar_ready = 1; slv_req.aw_valid = 1; mst_resp.aw_ready = 1;
    slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.w_ready = 1;
    tick;
    slv_req.ar_valid = 0; slv_req.aw_valid = 0; slv_req.w_valid = 0; iso = 1;
    tick;
    slv_req.ar_valid = 1; slv_req.aw_valid = 1; #1;
    chk("drain_block", {slv_resp.ar_ready, slv_resp.aw_ready, mst_req.ar_valid, mst_req.aw_valid}, 0);
    chk("drain_cnt", {rd_cnt, wr_cnt}, {3'd1, 2'd1});
    mst_resp.b_valid = 1; slv_req.b_ready = 1; mst_resp.r_valid = 1; slv_req.r_ready = 1; mst_resp.r.last = 1;
    tick;
    mst_resp.b_valid = 0; mst_resp.r_valid = 0; #1;
    chk("drain_empty", {rd_cnt, wr_cnt, isolated}, 0);
    tick;
    chk("isolated", isolated, 1);
    chk("iso_block", slv_resp.ar_ready, 0);
    iso = 0;
    tick;
    chk("resume_iso", isolated, 0);
    chk("resume_rdy", slv_resp.ar_ready, 1);
    tick;
    chk("resume_cnt", rd_cnt, 1);
    restart;
    // isolate arriving mid-handshake
    slv_req.aw_valid = 1; mst_resp.aw_ready = 0;
    tick;
    iso = 1;
    tick;
    chk("hold_vld1", mst_req.aw_valid, 1);
    tick;
    chk("hold_vld2", mst_req.aw_valid, 1);
    mst_resp.aw_ready = 1; slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.w_ready = 1; #1;
    chk("hold_hs", slv_resp.aw_ready, 1);
    tick;
    slv_req.aw_valid = 0; slv_req.w_valid = 0; #1;
    chk("hold_cnt", {wr_cnt, isolated}, {2'd1, 1'b0});
    tick;
    chk("hold_drain", isolated, 0);
    mst_resp.b_valid = 1; slv_req.b_ready = 1;
    tick;
    mst_resp.b_valid = 0;
    chk("hold_b", isolated, 0);
    tick;
    chk("hold_iso", isolated, 1);
    restart;
    // W presented before its AW
    slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.w_ready = 1; mst_resp.aw_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w_early", {slv_resp.w_ready, mst_req.w_valid}, 0);
      tick;
    end
    slv_req.aw_valid = 1; #1;
    chk("w_with_aw", {slv_resp.aw_ready, slv_resp.w_ready, mst_req.w_valid}, 3'b111);
    tick;
    slv_req.aw_valid = 0; #1;
    chk("w_pend_zero", {slv_resp.w_ready, wr_cnt}, {1'b0, 2'd1});
    restart;
    // same-cycle AW and B, then reset mid-burst
    slv_req.aw_valid = 1; mst_resp.aw_ready = 1; slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.w_ready = 1;
    tick;
    mst_resp.b_valid = 1; slv_req.b_ready = 1;
    tick;
    slv_req.aw_valid = 0; slv_req.w_valid = 0; mst_resp.b_valid = 0; #1;
    chk("aw_b_same", wr_cnt, 1);
    slv_req.aw_valid = 1; slv_req.aw.len = 3; slv_req.w_valid = 1; slv_req.w.last = 0;
    slv_req.ar_valid = 1; mst_resp.ar_ready = 1;
    tick;
    chk("pre_rst", {rd_cnt, wr_cnt}, {3'd1, 2'd2});
    rst_ni = 0; #1;
    chk("rst_mid", {rd_cnt, wr_cnt, isolated}, 0);
    restart;
    // randomized traffic against the reference model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(59) == 0) iso = ~iso;
      if (!slv_req.aw_valid && $urandom_range(1) == 1) begin
        slv_req.aw_valid = 1; slv_req.aw.len = 8'($urandom_range(3));
        slv_req.aw.addr = $urandom; slv_req.aw.id = 4'($urandom);
        up_w.push_back(int'(slv_req.aw.len) + 1);
      end
      if (!slv_req.w_valid && up_w.size() > 0 && $urandom_range(1) == 1) begin
        slv_req.w_valid = 1; slv_req.w.data = $urandom; slv_req.w.strb = 4'($urandom);
        slv_req.w.last = (up_beat == up_w[0] - 1);
      end
      if (!slv_req.ar_valid && $urandom_range(2) == 0) begin
        slv_req.ar_valid = 1; slv_req.ar.len = 8'($urandom_range(3));
        slv_req.ar.addr = $urandom; slv_req.ar.id = 4'($urandom);
      end
      slv_req.b_ready = 1'($urandom); slv_req.r_ready = 1'($urandom);
      mst_resp.aw_ready = 1'($urandom); mst_resp.w_ready = 1'($urandom); mst_resp.ar_ready = 1'($urandom);
      if (!mst_resp.b_valid && b_owed > 0 && $urandom_range(1) == 1) begin
        mst_resp.b_valid = 1; mst_resp.b.id = 4'($urandom); mst_resp.b.resp = 2'($urandom);
      end
      if (!mst_resp.r_valid && rd_q.size() > 0 && $urandom_range(1) == 1) begin
        mst_resp.r_valid = 1; mst_resp.r.last = (rd_q[0] == 1);
        mst_resp.r.data = $urandom; mst_resp.r.id = 4'($urandom); mst_resp.r.resp = 2'($urandom);
      end
      #4;
      p_aw = (m_mode == 0 && wr_out < 2 && w_open < 2) || m_awh;
      p_ar = (m_mode == 0 && rd_q.size() < 4) || m_arh;
      aw_hs = slv_req.aw_valid & mst_resp.aw_ready & p_aw;
      ar_hs = slv_req.ar_valid & mst_resp.ar_ready & p_ar;
      p_w = w_open > 0 || aw_hs;
      w_hs = slv_req.w_valid & mst_resp.w_ready & p_w;
      b_hs = mst_resp.b_valid & slv_req.b_ready;
      r_hs = mst_resp.r_valid & slv_req.r_ready;
      chk("rand_gate", {gates(), rd_cnt, wr_cnt, isolated},
          {slv_req.aw_valid & p_aw, mst_resp.aw_ready & p_aw, slv_req.w_valid & p_w, mst_resp.w_ready & p_w,
           slv_req.ar_valid & p_ar, mst_resp.ar_ready & p_ar, mst_resp.b_valid, slv_req.b_ready,
           mst_resp.r_valid, slv_req.r_ready, 3'(rd_q.size()), 2'(wr_out), m_mode == 2});
      chk("rand_payload", {mst_req.aw, mst_req.w, mst_req.ar, slv_resp.b, slv_resp.r},
          {slv_req.aw, slv_req.w, slv_req.ar, mst_resp.b, mst_resp.r});
      idle = wr_out == 0 && rd_q.size() == 0 && w_open == 0 && !m_awh && !m_arh;
      @(posedge clk);
      #1;
      if (!iso) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && idle) m_mode = 2;
      m_awh = slv_req.aw_valid & p_aw & ~mst_resp.aw_ready;
      m_arh = slv_req.ar_valid & p_ar & ~mst_resp.ar_ready;
      if (aw_hs) begin
        wr_out++; w_open++; slv_req.aw_valid = 0;
      end
      if (ar_hs) begin
        rd_q.push_back(int'(slv_req.ar.len) + 1); slv_req.ar_valid = 0;
      end
      if (w_hs) begin
        if (slv_req.w.last) begin
          w_open--; b_owed++; void'(up_w.pop_front()); up_beat = 0;
        end else up_beat++;
        slv_req.w_valid = 0;
      end
      if (b_hs) begin
        wr_out--; b_owed--; mst_resp.b_valid = 0;
      end
      if (r_hs) begin
        if (mst_resp.r.last) void'(rd_q.pop_front());
        else rd_q[0]--;
        mst_resp.r_valid = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
